// File: rtl/inst_fifo_multi.sv
// Multi-port instruction buffer: up to FETCH_W {pc, instr} pairs in per cycle,
// up to ISSUE_W oldest entries presented in program order, with flush.
module inst_fifo_multi #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 16,
  parameter int PC_W    = 32,
  parameter int INST_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [FETCH_W-1:0]            push_en,
  input  logic [FETCH_W*PC_W-1:0]       push_pc,
  input  logic [FETCH_W*INST_W-1:0]     push_inst,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  input  logic [$clog2(ISSUE_W+1)-1:0]  pop_num,
  output logic [ISSUE_W-1:0]            out_valid,
  output logic [ISSUE_W*PC_W-1:0]       out_pc,
  output logic [ISSUE_W*INST_W-1:0]     out_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] wr_idx [FETCH_W];
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] eff_pop;
  logic          push_ok;

  assign full    = (CW'(DEPTH) - count_q) < CW'(FETCH_W);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = !full && !flush;
  assign eff_pop = (CW'(pop_num) > count_q) ? count_q : CW'(pop_num);

  // Enabled slots are packed into consecutive entries starting at wr_ptr.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      wr_idx[i] = wr_ptr_q + AW'(push_cnt);
      push_cnt  = push_cnt + CW'(push_en[i]);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(eff_pop);
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(push_cnt);
        count_d  = count_q + push_cnt - eff_pop;
      end else begin
        count_d  = count_q - eff_pop;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage deliberately has no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (push_en[i]) begin
          pc_mem[wr_idx[i]]   <= push_pc[i*PC_W +: PC_W];
          inst_mem[wr_idx[i]] <= push_inst[i*INST_W +: INST_W];
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      out_valid[k] = count_q > CW'(k);
      if (out_valid[k]) begin
        out_pc[k*PC_W +: PC_W]       = pc_mem[rd_ptr_q + AW'(k)];
        out_inst[k*INST_W +: INST_W] = inst_mem[rd_ptr_q + AW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_inst_fifo_multi.sv
// Self-checking bench for inst_fifo_multi: a queue scoreboard tracks every
// accepted entry and is compared against the head slots after each edge.
module tb_inst_fifo_multi;

  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 16;

  logic          clk;
  logic          clk_en;
  logic          rst;
  logic          flush;
  logic [1:0]    push_en;
  logic [63:0]   push_pc;
  logic [63:0]   push_inst;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic [1:0]    pop_num;
  logic [1:0]    out_valid;
  logic [63:0]   out_pc;
  logic [63:0]   out_inst;

  logic [63:0]   sb [$];
  int            checks;
  int            failures;

  inst_fifo_multi #(
    .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .PC_W(32), .INST_W(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_en(push_en), .push_pc(push_pc), .push_inst(push_inst),
    .full(full), .empty(empty), .count(count),
    .pop_num(pop_num),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference queue, step past the edge.
  task automatic applyStimulus(input logic [1:0] en, input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [31:0] in0, input logic [31:0] in1,
                               input logic [1:0] popn, input logic fl);
    int n;
    bit mfull;
    push_en   = en;
    push_pc   = {pc1, pc0};
    push_inst = {in1, in0};
    pop_num   = popn;
    flush     = fl;
    n     = sb.size();
    mfull = (DEPTH - n) < FETCH_W;
    if (fl) begin
      sb.delete();
    end else begin
      for (int i = 0; i < int'(popn) && i < n; i++) void'(sb.pop_front());
      if (!mfull) begin
        if (en[0]) sb.push_back({pc0, in0});
        if (en[1]) sb.push_back({pc1, in1});
      end
    end
    @(posedge clk);
    #1;
    push_en = '0;
    pop_num = '0;
    flush   = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    int n;
    logic [63:0] e;
    n = sb.size();
    checkVal({tag, ".count"}, 64'(count), 64'(n));
    checkVal({tag, ".empty"}, 64'(empty), 64'(n == 0));
    checkVal({tag, ".full"}, 64'(full), 64'((DEPTH - n) < FETCH_W));
    checkVal({tag, ".valid"}, 64'(out_valid), {62'd0, n > 1, n > 0});
    for (int k = 0; k < ISSUE_W; k++) begin
      e = (n > k) ? sb[k] : 64'd0;
      checkVal($sformatf("%s.pc%0d", tag, k), 64'(out_pc[k*32 +: 32]), 64'(e[63:32]));
      checkVal($sformatf("%s.inst%0d", tag, k), 64'(out_inst[k*32 +: 32]), 64'(e[31:0]));
    end
  endtask

  initial begin
    logic [31:0] pc_next;
    logic [31:0] p0, p1;
    logic [1:0]  en;
    logic [1:0]  pn;
    int          n;

    checks = 0; failures = 0;
    clk_en = 1'b0; rst = 1'b0; flush = 1'b0;
    push_en = '0; push_pc = '0; push_inst = '0; pop_num = '0;

    // Asynchronous reset with the clock stopped.
    #2 rst = 1'b1;
    #1 checkOutput("rst_async");
    #2 rst = 1'b0;
    #1 checkOutput("rst_release");
    clk_en = 1'b1;

    $display("[TB] basic dual push / pop");
    applyStimulus(2'b11, 32'hBFC00000, 32'hBFC00004, 32'h24080001, 32'h24090002, 2'd0, 1'b0);
    checkOutput("push11");
    checkVal("push11.pc0_const", 64'(out_pc[31:0]), 64'h0000_0000_BFC0_0000);
    checkVal("push11.pc1_const", 64'(out_pc[63:32]), 64'h0000_0000_BFC0_0004);
    applyStimulus(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    checkOutput("pop2");

    $display("[TB] sparse push and clamped pop");
    applyStimulus(2'b10, 32'hDEAD0000, 32'hBFC00008, 32'h0, 32'h240A0003, 2'd0, 1'b0);
    checkOutput("push10");
    checkVal("push10.pc0_const", 64'(out_pc[31:0]), 64'h0000_0000_BFC0_0008);
    applyStimulus(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    checkOutput("pop_clamp");

    $display("[TB] fill to full");
    pc_next = 32'h0000_1000;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(2'b11, pc_next, pc_next + 4, ~pc_next, ~(pc_next + 4), 2'd0, 1'b0);
      pc_next += 8;
    end
    checkOutput("fill");
    checkVal("fill.count_const", 64'(count), 64'd16);
    applyStimulus(2'b11, 32'hBAD00000, 32'hBAD00004, 0, 0, 2'd0, 1'b0);
    checkOutput("push_when_full");
    applyStimulus(2'b00, 0, 0, 0, 0, 2'd1, 1'b0);
    checkOutput("pop_to_15");
    checkVal("pop_to_15.full_const", 64'(full), 64'd1);
    applyStimulus(2'b11, 32'hBAD00008, 32'hBAD0000C, 0, 0, 2'd1, 1'b0);
    checkOutput("pop_to_14");
    checkVal("pop_to_14.full_const", 64'(full), 64'd0);

    $display("[TB] random traffic across wrap");
    for (int c = 0; c < 40; c++) begin
      en = 2'($urandom_range(0, 3));
      n  = sb.size();
      p0 = 32'hBAD10000; p1 = 32'hBAD10004;
      if ((DEPTH - n) >= FETCH_W) begin
        if (en[0]) begin p0 = pc_next; pc_next += 4; end
        if (en[1]) begin p1 = pc_next; pc_next += 4; end
      end
      pn = 2'($urandom_range(0, (n < 2) ? n : 2));
      applyStimulus(en, p0, p1, ~p0, ~p1, pn, 1'b0);
      checkOutput($sformatf("wrap%0d", c));
      if (out_valid[1])
        checkVal($sformatf("wrap%0d.seq", c), 64'(out_pc[63:32]), 64'(out_pc[31:0] + 32'd4));
    end

    $display("[TB] flush with concurrent push and pop");
    for (int i = 0; i < 20 && sb.size() > 0; i++)
      applyStimulus(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    checkOutput("drain");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b11, pc_next, pc_next + 4, ~pc_next, ~(pc_next + 4), 2'd0, 1'b0);
      pc_next += 8;
    end
    checkOutput("pre_flush");
    checkVal("pre_flush.count_const", 64'(count), 64'd6);
    applyStimulus(2'b11, 32'hF1F10000, 32'hF1F10004, 0, 0, 2'd2, 1'b1);
    checkOutput("flush");
    applyStimulus(2'b00, 0, 0, 0, 0, 2'd0, 1'b0);
    checkOutput("post_flush_idle");
    applyStimulus(2'b01, 32'h0000_9000, 32'h0, 32'h1234_5678, 32'h0, 2'd0, 1'b0);
    checkOutput("post_flush_push");

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(2'b11, 32'h0000_9004, 32'h0000_9008, 32'h1, 32'h2, 2'd0, 1'b0);
    checkOutput("pre_reset");
    #2 rst = 1'b1;
    sb.delete();
    #1 checkOutput("mid_reset");
    rst = 1'b0;
    applyStimulus(2'b11, 32'h0000_A000, 32'h0000_A004, 32'h3, 32'h4, 2'd0, 1'b0);
    checkOutput("after_reset_push");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/inst_fifo_multi.md
Name: inst_fifo_multi

Overview:
- Parametrised multi-port instruction buffer between fetch and the decoder bank of the dual-issue pipeline.
- Accepts up to FETCH_W {pc, instr} pairs per cycle and presents up to ISSUE_W oldest entries to the decoders in program order.
- Issue logic consumes 0..ISSUE_W entries per cycle, always from the head.
- Decouples fetch from issue stalls. Supports pipeline flush for branch mispredict and exceptions.

Parameters:
- FETCH_W, 2, write ports (pairs pushed per cycle), >=1
- ISSUE_W, 2, read ports (pairs presented per cycle), >=1
- DEPTH, 16, entries; power of two, >= 2*max(FETCH_W,ISSUE_W)
- PC_W, 32, pc width
- INST_W, 32, instruction width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  discard all contents
- push_en  in  FETCH_W  per-slot valid, any bit pattern allowed
- push_pc  in  FETCH_W*PC_W  slot i at [i*PC_W +: PC_W]
- push_inst  in  FETCH_W*INST_W  slot i at [i*INST_W +: INST_W]
- full  out  1  free entries < FETCH_W
- empty  out  1  count == 0
- count  out  $clog2(DEPTH+1)  occupied entries
- pop_num  in  $clog2(ISSUE_W+1)  entries consumed this cycle
- out_valid  out  ISSUE_W  thermometer; bit k = entry head+k present
- out_pc  out  ISSUE_W*PC_W  head+k pc
- out_inst  out  ISSUE_W*INST_W  head+k instruction

Behaviour:
- Storage is a circular array with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Count is a separate register.
- Reset (async, rst=1) sets rd_ptr=0, wr_ptr=0, count=0.
  - Outputs during and after reset: empty=1, full=0, out_valid=0, out_pc=0, out_inst=0.
  - Storage array is not reset.
- Outputs are combinational from registered state only. There is no write-to-read bypass, so a pushed entry is visible at out_* the cycle after the push edge (latency 1).
- out_valid[k] = (count > k). out_pc/out_inst slot k are forced to 0 when out_valid[k]=0.
- full = (DEPTH - count) < FETCH_W, computed from registered count.
  - A same-cycle pop does not relax full.
  - Fetch must hold while full=1.
- Push is accepted only when full=0 and flush=0.
  - Set push_en bits are compacted in ascending slot order into consecutive entries starting at wr_ptr. Example: push_en=2'b10 writes only slot 1, at wr_ptr.
  - wr_ptr += popcount(push_en).
- When full=1, push is ignored entirely: no partial write, no pointer change.
- Pop: eff_pop = min(pop_num, count). rd_ptr += eff_pop. An over-request is clamped silently.
- Simultaneous push and pop update count by popcount(accepted push) - eff_pop in one cycle. Push writes never collide with live entries because full is checked against pre-pop count.
- Flush has the highest priority below rst. At the next edge pointers and count go to 0, and any same-cycle push and pop are discarded.
- Wrap-around: entry order across the DEPTH-1 to 0 boundary is preserved for both read and write ports.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Deassertion takes effect from the next clk edge.

Test Plan:
1. rst pulse with no clk activity -> immediately empty=1, count=0, out_valid=2'b00, out_pc=0, out_inst=0, full=0.
2. Push push_en=2'b11 (pc 0xBFC00000/0xBFC00004, inst 0x24080001/0x24090002) -> next cycle out_valid=2'b11, out_pc slot0=0xBFC00000, slot1=0xBFC00004, count=2. Then pop_num=2 -> next cycle empty=1.
3. push_en=2'b10 only (pc 0xBFC00008) into empty FIFO -> next cycle out_valid=2'b01, out_pc slot0=0xBFC00008, count=1. Then pop_num=2 -> clamped to 1, count=0.
4. Fill: push 2 per cycle for 8 cycles with pop_num=0 -> count=16, full=1. A 9th push is ignored, count=16. Pop 1 -> count=15, full stays 1. Pop 1 more -> count=14, full=0.
5. Wrap: run 40 cycles of random push patterns and pops (pop_num<=count) with incrementing pc -> out_pc sequence strictly +4 with no gaps or duplicates across pointer wrap.
6. With count=6, assert flush together with push_en=2'b11 and pop_num=2 -> next cycle count=0, empty=1, out_valid=0. Pushed pcs never appear at out_pc.
